// File: rtl/mmu_pkg.sv
// Shared MMU definitions: FSM state encoding and signed saturation helpers.
package mmu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } mmu_state_e;

    // Saturation bounds for the default 16-bit element width
    localparam logic signed [15:0] SAT_MAX_16 = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN_16 = 16'sh8000;

    // Largest value representable in a w-bit signed word
    function automatic logic signed [63:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a w-bit signed word
    function automatic logic signed [63:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // True when v does not fit in a w-bit signed word
    function automatic logic sat_hit(input logic signed [63:0] v, input int unsigned w);
        return (v > sat_max(w)) || (v < sat_min(w));
    endfunction

    // Clamp v to the w-bit signed range
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int unsigned w);
        if (v > sat_max(w)) begin
            return sat_max(w);
        end else if (v < sat_min(w)) begin
            return sat_min(w);
        end
        return v;
    endfunction

endpackage

// File: rtl/mmu_tiled_if.sv
// Job handshake and matrix bus of the tiled matrix-multiply unit.
interface mmu_tiled_if #(
    parameter int unsigned NUM_ROWS_A = 4,
    parameter int unsigned NUM_COLS_A = 8,
    parameter int unsigned NUM_COLS_B = 4,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                         start;
    logic                         accum_en;
    logic signed [DATA_WIDTH-1:0] mat_in1      [NUM_ROWS_A][NUM_COLS_A];
    logic signed [DATA_WIDTH-1:0] mat_in2      [NUM_COLS_A][NUM_COLS_B];
    logic signed [DATA_WIDTH-1:0] mat_in_accum [NUM_ROWS_A][NUM_COLS_B];
    logic                         busy;
    logic                         done;
    logic                         overflow;
    logic signed [DATA_WIDTH-1:0] mat_out      [NUM_ROWS_A][NUM_COLS_B];

    modport master (
        output start, accum_en, mat_in1, mat_in2, mat_in_accum,
        input  busy, done, overflow, mat_out
    );

    modport slave (
        input  start, accum_en, mat_in1, mat_in2, mat_in_accum,
        output busy, done, overflow, mat_out
    );
endinterface

// File: rtl/mmu_mac_cell.sv
// One output cell: K_STEP saturating fixed-point multipliers, a product
// register and a saturating accumulator that adds products in k order.
module mmu_mac_cell
    import mmu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIXED_PNT  = 8,
    parameter int unsigned K_STEP     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         init_i,
    input  logic signed [DATA_WIDTH-1:0] init_val_i,
    input  logic                         load_i,
    input  logic signed [DATA_WIDTH-1:0] a_i [K_STEP],
    input  logic signed [DATA_WIDTH-1:0] b_i [K_STEP],
    input  logic                         acc_en_i,
    output logic signed [DATA_WIDTH-1:0] acc_o,
    output logic                         sat_o
);
    logic signed [63:0]           prod_full [K_STEP];
    logic signed [DATA_WIDTH-1:0] prod_d    [K_STEP];
    logic signed [DATA_WIDTH-1:0] prod_q    [K_STEP];
    logic                         prod_sat;
    logic signed [63:0]           acc_sum   [K_STEP];
    logic signed [DATA_WIDTH-1:0] acc_d;
    logic signed [DATA_WIDTH-1:0] acc_q;
    logic                         acc_sat;

    // Full-precision products, floor shift to fixed point, then saturate
    always_comb begin
        prod_sat = 1'b0;
        for (int unsigned k = 0; k < K_STEP; k++) begin
            prod_full[k] = (64'(a_i[k]) * 64'(b_i[k])) >>> FIXED_PNT;
            prod_d[k]    = DATA_WIDTH'(sat_clip(prod_full[k], DATA_WIDTH));
            if (sat_hit(prod_full[k], DATA_WIDTH)) begin
                prod_sat = 1'b1;
            end
        end
    end

    // Chained saturating adds so each k clips before the next is added
    always_comb begin
        acc_d   = acc_q;
        acc_sat = 1'b0;
        for (int unsigned k = 0; k < K_STEP; k++) begin
            acc_sum[k] = 64'(acc_d) + 64'(prod_q[k]);
            if (sat_hit(acc_sum[k], DATA_WIDTH)) begin
                acc_sat = 1'b1;
            end
            acc_d = DATA_WIDTH'(sat_clip(acc_sum[k], DATA_WIDTH));
        end
    end

    assign sat_o = (load_i & prod_sat) | (acc_en_i & acc_sat);
    assign acc_o = acc_q;

    // Product register and accumulator state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '{default: '0};
            acc_q  <= '0;
        end else begin
            if (load_i) begin
                prod_q <= prod_d;
            end
            if (init_i) begin
                acc_q <= init_val_i;
            end else if (acc_en_i) begin
                acc_q <= acc_d;
            end
        end
    end

endmodule

// File: rtl/mmu_tiled.sv
// Tiled fixed-point matrix multiply: captures A and B on start, streams
// K_STEP-wide chunks of the reduction into a grid of MAC cells, and
// publishes the saturated result with a one-cycle done pulse.
module mmu_tiled
    import mmu_pkg::*;
#(
    parameter int unsigned NUM_ROWS_A = 4,
    parameter int unsigned NUM_COLS_A = 8,
    parameter int unsigned NUM_COLS_B = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIXED_PNT  = 8,
    parameter int unsigned K_STEP     = 2
) (
    input  logic         clk,
    input  logic         rst,
    mmu_tiled_if.slave   bus
);
    localparam int unsigned N     = NUM_COLS_A / K_STEP;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned KW    = (NUM_COLS_A > 1) ? $clog2(NUM_COLS_A) : 1;
    localparam int unsigned CELLS = NUM_ROWS_A * NUM_COLS_B;

    mmu_state_e                   state_q, state_d;
    logic [CNT_W-1:0]             cnt_q;
    logic                         start_acc, load, acc_en, out_load;
    logic [KW-1:0]                base;
    logic signed [DATA_WIDTH-1:0] a_q       [NUM_ROWS_A][NUM_COLS_A];
    logic signed [DATA_WIDTH-1:0] b_q       [NUM_COLS_A][NUM_COLS_B];
    logic signed [DATA_WIDTH-1:0] acc       [NUM_ROWS_A][NUM_COLS_B];
    logic signed [DATA_WIDTH-1:0] mat_out_q [NUM_ROWS_A][NUM_COLS_B];
    logic [CELLS-1:0]             sat_vec;
    logic                         done_q;
    logic                         overflow_q;

    // Next-state and per-state datapath controls
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        load      = 1'b0;
        acc_en    = 1'b0;
        out_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    start_acc = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                load   = 1'b1;
                acc_en = (cnt_q != '0);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                acc_en  = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                out_load = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Chunk step counter, advanced once per product load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (start_acc) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Operand capture so inputs may change once the job is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '{default: '0};
            b_q <= '{default: '0};
        end else if (start_acc) begin
            a_q <= bus.mat_in1;
            b_q <= bus.mat_in2;
        end
    end

    // Result publication, done pulse and per-job sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mat_out_q  <= '{default: '0};
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= out_load;
            if (out_load) begin
                mat_out_q <= acc;
            end
            if (start_acc) begin
                overflow_q <= 1'b0;
            end else if (|sat_vec) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // First reduction index of the chunk being loaded this cycle
    always_comb begin
        base = KW'(cnt_q) * KW'(K_STEP);
    end

    for (genvar r = 0; r < NUM_ROWS_A; r++) begin : g_row
        for (genvar c = 0; c < NUM_COLS_B; c++) begin : g_col
            logic signed [DATA_WIDTH-1:0] a_chunk [K_STEP];
            logic signed [DATA_WIDTH-1:0] b_chunk [K_STEP];
            logic signed [DATA_WIDTH-1:0] init_val;

            // Route the current chunk of row r of A and column c of B
            always_comb begin
                for (int unsigned j = 0; j < K_STEP; j++) begin
                    a_chunk[j] = a_q[r][base + KW'(j)];
                    b_chunk[j] = b_q[base + KW'(j)][c];
                end
                init_val = bus.accum_en ? bus.mat_in_accum[r][c] : '0;
            end

            mmu_mac_cell #(
                .DATA_WIDTH (DATA_WIDTH),
                .FIXED_PNT  (FIXED_PNT),
                .K_STEP     (K_STEP)
            ) u_cell (
                .clk        (clk),
                .rst        (rst),
                .init_i     (start_acc),
                .init_val_i (init_val),
                .load_i     (load),
                .a_i        (a_chunk),
                .b_i        (b_chunk),
                .acc_en_i   (acc_en),
                .acc_o      (acc[r][c]),
                .sat_o      (sat_vec[r*NUM_COLS_B + c])
            );
        end
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.mat_out  = mat_out_q;

endmodule

// File: tb/tb_mmu_tiled.sv
// Directed bench for mmu_tiled at default parameters (1.0 = 0x0100).
module tb_mmu_tiled;
    localparam int unsigned R = 4;
    localparam int unsigned K = 8;
    localparam int unsigned C = 4;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mmu_tiled_if #(.NUM_ROWS_A(R), .NUM_COLS_A(K), .NUM_COLS_B(C), .DATA_WIDTH(W)) bus ();

    mmu_tiled #(
        .NUM_ROWS_A (R),
        .NUM_COLS_A (K),
        .NUM_COLS_B (C),
        .DATA_WIDTH (W),
        .FIXED_PNT  (8),
        .K_STEP     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // A: diagonal/off-diagonal values; B and accumulate matrices uniform
    task automatic set_inputs(input logic [15:0] a_diag, input logic [15:0] a_off,
                              input logic [15:0] b_val, input logic [15:0] acc_val,
                              input logic acc_en);
        for (int r = 0; r < R; r++)
            for (int k = 0; k < K; k++)
                bus.mat_in1[r][k] = (r == k) ? a_diag : a_off;
        for (int k = 0; k < K; k++)
            for (int c = 0; c < C; c++)
                bus.mat_in2[k][c] = b_val;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                bus.mat_in_accum[r][c] = acc_val;
        bus.accum_en = acc_en;
    endtask

    // One-cycle start; inputs are scrambled right after acceptance
    task automatic launch();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        set_inputs(16'h1357, 16'h2468, 16'h0F0F, 16'h3C3C, ~bus.accum_en);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] exp);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                chk($sformatf("%s[%0d][%0d]", tag, r, c), unsigned'(bus.mat_out[r][c]), exp);
    endtask

    task automatic run_std(input string tag, input logic [15:0] a_diag, input logic [15:0] a_off,
                           input logic [15:0] b_val, input logic [15:0] acc_val, input logic acc_en,
                           input logic [15:0] exp_out, input logic exp_ovf);
        int lat;
        set_inputs(a_diag, a_off, b_val, acc_val, acc_en);
        launch();
        wait_done(lat);
        chk({tag, "_lat"}, lat, 6);
        check_out({tag, "_out"}, exp_out);
        chk({tag, "_ovf"}, bus.overflow, exp_ovf);
        chk({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        int lat;
        int ndone;

        rst = 1'b1;
        bus.start = 1'b0;
        set_inputs(16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_ovf", bus.overflow, 1'b0);
        check_out("rst_out", 16'h0000);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_std("ident", 16'h0100, 16'h0000, 16'h0200, 16'h0000, 1'b0, 16'h0200, 1'b0);
        run_std("accum", 16'h0100, 16'h0000, 16'h0200, 16'h0080, 1'b1, 16'h0280, 1'b0);
        run_std("satp", 16'h7F00, 16'h7F00, 16'h0200, 16'h0000, 1'b0, 16'h7FFF, 1'b1);
        run_std("satn", 16'h7F00, 16'h7F00, 16'hFE00, 16'h0000, 1'b0, 16'h8000, 1'b1);
        // -1/256 per product under floor shift, eight of them
        run_std("floor", 16'h0001, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 16'hFFF8, 1'b0);

        // Result held between done pulses
        repeat (3) @(posedge clk);
        #1;
        chk("hold_done", bus.done, 1'b0);
        check_out("hold", 16'hFFF8);

        // Start while busy is ignored
        set_inputs(16'h0100, 16'h0000, 16'h0200, 16'h0000, 1'b0);
        launch();
        chk("ign_busy", bus.busy, 1'b1);
        @(posedge clk);
        #1;
        set_inputs(16'h0100, 16'h0000, 16'h0200, 16'h0080, 1'b1);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_out("ign_mid", 16'hFFF8);
        wait_done(lat);
        chk("ign_lat", lat, 4);
        check_out("ign_out", 16'h0200);
        ndone = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        chk("ign_extra", ndone, 0);

        // Back-to-back: second start issued in the done cycle
        set_inputs(16'h0100, 16'h0100, 16'h0100, 16'h0000, 1'b0);
        launch();
        wait_done(lat);
        chk("b2b1_lat", lat, 6);
        check_out("b2b1_out", 16'h0800);
        set_inputs(16'h0100, 16'h0000, 16'h0200, 16'h0000, 1'b0);
        launch();
        wait_done(lat);
        chk("b2b2_lat", lat, 6);
        check_out("b2b2_out", 16'h0200);

        // Reset in the middle of RUN aborts the job
        set_inputs(16'h0100, 16'h0000, 16'h0200, 16'h0080, 1'b1);
        launch();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        check_out("abort_out", 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        chk("abort_nodone", ndone, 0);
        run_std("post", 16'h0100, 16'h0000, 16'h0200, 16'h0000, 1'b0, 16'h0200, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
